retospect_cfg_loader: RTL and testbench

- Sequencer that owns the neurochip configuration shift chain: clockbox first, then every CNB cell.
- Accepts configuration bytes from a host-side byte stream using a valid/ready handshake.
- Serialises the bytes LSB-first onto bs_in and drives config_en for exactly CHAIN_LEN shift cycles.
- Then pulses reset_nn to re-arm neuron state and the clock counters, and reports completion. It sits between the pad/host interface and the fabric's config_en/bs_in/reset_nn nets.

---
 rtl/retospect_cfg_loader_if.sv | 21 ++
 rtl/retospect_cfg_loader.sv | 233 +++++++++++++++++++++++
 tb/tb_retospect_cfg_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retospect_cfg_loader_if.sv
// Host-side byte stream into the configuration loader.
//   in_data  : configuration byte, bit0 is shifted onto the chain first
//   in_valid : in_data is valid (driven by the host, master side)
//   in_ready : loader accepts a byte this cycle (driven by the loader, slave side)
interface retospect_cfg_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/retospect_cfg_loader.sv
// Configuration shift-chain sequencer (clockbox first, then every CNB cell).
// Takes bytes from the host stream, serialises them LSB-first onto bs_in while
// holding config_en for exactly CHAIN_LEN shift cycles, then pulses reset_nn
// for NN_PULSE cycles and reports completion with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : single-cycle load request, only honoured while idle
//   abort        : cancels a load in LOAD or NNRST
//   in_if        : byte stream (in_data / in_valid / in_ready)
//   config_en    : chain shift enable
//   bs_in        : chain serial data
//   bs_out       : chain tail bit (only used with the readback CRC)
//   reset_nn     : neuron/counter re-arm pulse
//   busy         : high in LOAD, NNRST and DONE
//   done         : one-cycle completion pulse
//   aborted      : sticky abort flag, cleared by the next accepted start
//   bit_count    : bits shifted so far in the current load
//   readback_crc : CRC-8 (poly 0x07) of bs_out during shifting, only when
//                  RETOSPECT_CFG_READBACK_CRC_EN is defined
//
// Optional feature macro: RETOSPECT_CFG_READBACK_CRC_EN
module retospect_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 573,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned NN_PULSE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  retospect_cfg_loader_if.slave in_if,
  output logic                  config_en,
  output logic                  bs_in,
  input  logic                  bs_out,
  output logic                  reset_nn,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_W-1:0]      bit_count
`ifdef RETOSPECT_CFG_READBACK_CRC_EN
  ,
  output logic [7:0]            readback_crc
`endif
);

  localparam int unsigned      NN_W      = (NN_PULSE > 1) ? $clog2(NN_PULSE) : 1;
  localparam logic [CNT_W-1:0] CHAIN_W   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] BYTE_BITS = CNT_W'(8);
  localparam logic [NN_W-1:0]  NN_LAST   = NN_W'(NN_PULSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_NNRST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_q,     state_d;
  logic [7:0]       buf_q,       buf_d;
  logic [3:0]       buf_cnt_q,   buf_cnt_d;    // valid bits left in buf_q, current one included
  logic [CNT_W-1:0] req_q,       req_d;        // bits taken from accepted bytes so far
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [NN_W-1:0]  nn_cnt_q,    nn_cnt_d;
  logic             aborted_q,   aborted_d;
  logic             config_en_q, config_en_d;
  logic             bs_in_q,     bs_in_d;
  logic             in_ready_q,  in_ready_d;
  logic             reset_nn_q,  reset_nn_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;

  logic             shift_c;
  logic             accept_c;
  logic [CNT_W-1:0] rem_c;
  logic [3:0]       nbits_c;

  // Shift happens whenever the buffer holds a bit; a byte lands on a handshake.
  assign shift_c  = (buf_cnt_q != 4'd0);
  assign accept_c = in_if.in_valid && in_ready_q;

  // The final byte only contributes what is left of the chain.
  assign rem_c   = CHAIN_W - req_q;
  assign nbits_c = (rem_c >= BYTE_BITS) ? 4'd8 : rem_c[3:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    req_d       = req_q;
    bit_count_d = bit_count_q;
    nn_cnt_d    = nn_cnt_q;
    aborted_d   = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        // start beats a coincident abort while idle
        if (start) begin
          state_d     = ST_LOAD;
          buf_d       = '0;
          buf_cnt_d   = '0;
          req_d       = '0;
          bit_count_d = '0;
          aborted_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (shift_c) begin
          bit_count_d = bit_count_q + CNT_W'(1);
          buf_d       = buf_q >> 1;
          buf_cnt_d   = buf_cnt_q - 4'd1;
        end
        // A refill on the final-bit cycle overwrites the shifted remnant.
        if (accept_c) begin
          buf_d     = in_if.in_data;
          buf_cnt_d = nbits_c;
          req_d     = req_q + CNT_W'(nbits_c);
        end
        if (abort) begin
          state_d   = ST_IDLE;
          buf_d     = '0;
          buf_cnt_d = '0;
          aborted_d = 1'b1;
        end else if (shift_c && (bit_count_q == LAST_BIT)) begin
          state_d   = ST_NNRST;
          buf_d     = '0;
          buf_cnt_d = '0;
          nn_cnt_d  = '0;
        end
      end

      ST_NNRST: begin
        if (abort) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (nn_cnt_q == NN_LAST) begin
          state_d = ST_DONE;
        end else begin
          nn_cnt_d = nn_cnt_q + NN_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    config_en_d = (buf_cnt_d != 4'd0);
    bs_in_d     = config_en_d & buf_d[0];
    in_ready_d  = (state_d == ST_LOAD) && (req_d < CHAIN_W) && (buf_cnt_d <= 4'd1);
    reset_nn_d  = (state_d == ST_NNRST);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      req_q       <= '0;
      bit_count_q <= '0;
      nn_cnt_q    <= '0;
      aborted_q   <= 1'b0;
      config_en_q <= 1'b0;
      bs_in_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      reset_nn_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      req_q       <= req_d;
      bit_count_q <= bit_count_d;
      nn_cnt_q    <= nn_cnt_d;
      aborted_q   <= aborted_d;
      config_en_q <= config_en_d;
      bs_in_q     <= bs_in_d;
      in_ready_q  <= in_ready_d;
      reset_nn_q  <= reset_nn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign config_en      = config_en_q;
  assign bs_in          = bs_in_q;
  assign reset_nn       = reset_nn_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign bit_count      = bit_count_q;

`ifdef RETOSPECT_CFG_READBACK_CRC_EN
  logic [7:0] crc_q, crc_d;

  // CRC-8 over the old chain contents leaving through bs_out while shifting.
  always_comb begin
    crc_d = crc_q;
    if ((state_q == ST_IDLE) && start) begin
      crc_d = '0;
    end else if (config_en_q) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ bs_out) ? 8'h07 : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign readback_crc = crc_q;
`else
  logic unused_bs_out;
  assign unused_bs_out = bs_out;
`endif

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Randomised self-checking bench for retospect_cfg_loader; the reference model
// tracks the chain load as a queue of pending bits plus a phase counter.
module tb_retospect_cfg_loader;

  localparam int unsigned CHAIN_LEN = 573;
  localparam int unsigned CNT_W     = 10;
  localparam int unsigned NN_PULSE  = 1;
  localparam int unsigned NBYTES    = (CHAIN_LEN + 7) / 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             bs_out;
  logic             config_en;
  logic             bs_in;
  logic             reset_nn;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] bit_count;
`ifdef RETOSPECT_CFG_READBACK_CRC_EN
  logic [7:0]       readback_crc;
`endif

  retospect_cfg_loader_if bus ();

  retospect_cfg_loader #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W),
    .NN_PULSE  (NN_PULSE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .in_if        (bus.slave),
    .config_en    (config_en),
    .bs_in        (bs_in),
    .bs_out       (bs_out),
    .reset_nn     (reset_nn),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .bit_count    (bit_count)
`ifdef RETOSPECT_CFG_READBACK_CRC_EN
    ,
    .readback_crc (readback_crc)
`endif
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_crc = 8'h00;
  logic       m_aborted = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Polynomial x^8+x^2+x+1, message bit entering at the top.
  function automatic logic [7:0] crc_next(input logic [7:0] c, input logic b);
    logic [8:0] r;
    r = {c, 1'b0};
    if (c[7] ^ b) r = r ^ 9'h107;
    return r[7:0];
  endfunction

  task automatic check_crc(input string tag);
`ifdef RETOSPECT_CFG_READBACK_CRC_EN
    check(tag, 32'(readback_crc), 32'(m_crc));
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask

  // One complete load (or aborted load) with per-cycle comparison against the model.
  task automatic run_load(input int gap_mode, input int abort_at, input bit last_ff,
                          input bit bs_ones, input bit first_a5, input bit start_abort,
                          input bit abort_in_done);
    logic [7:0] byt [NBYTES];
    int         gap [NBYTES];
    logic       q [$];
    int req, shifted, sh0, bi, wait_c, phase, nnc, cfg_seen, cur_run, max_run, qb, n;
    bit exp_cfg, ab_now, ab_fired;
    logic b;

    for (int i = 0; i < int'(NBYTES); i++) begin
      byt[i] = 8'($urandom);
      gap[i] = (gap_mode == 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    end
    if (first_a5) byt[0] = 8'hA5;
    if (last_ff) byt[NBYTES-1] = 8'hFF;
    if (gap_mode == 2) gap[3] = 10;

    req = 0; shifted = 0; bi = 0; wait_c = gap[0]; phase = 0; nnc = 0;
    cfg_seen = 0; cur_run = 0; max_run = 0; ab_fired = 1'b0;
    m_crc = 8'h00;
    m_aborted = 1'b0;

    @(negedge clk);
    start = 1'b1;
    abort = start_abort;
    bus.in_valid = 1'b0;

    for (int cyc = 0; cyc < 4000 && phase != 5; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      qb  = q.size();
      sh0 = shifted;
      exp_cfg = (phase == 0) && (qb > 0);

      check("config_en", 32'(config_en), 32'(exp_cfg));
      check("reset_nn", 32'(reset_nn), 32'(phase == 1));
      check("done", 32'(done), 32'(phase == 2));
      check("busy", 32'(busy), 32'(phase <= 2));
      check("aborted", 32'(aborted), 32'(phase == 4));
      check("in_ready", 32'(bus.in_ready),
            32'((phase == 0) && (req < int'(CHAIN_LEN)) && (qb <= 1)));
      if (phase != 4) check("bit_count", 32'(bit_count), 32'(shifted));
      if (cyc == 0) check_crc("crc_cleared");
      if (phase == 3 || phase == 4) check_crc("crc_final");
      if (phase == 3) begin
        check("cfg_cycles", 32'(cfg_seen), 32'(CHAIN_LEN));
        if (gap_mode == 0) check("cfg_gapfree", 32'(max_run), 32'(CHAIN_LEN));
      end

      if (config_en) begin
        cfg_seen++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end

      // bs_out set now is what the DUT samples at the end of this cycle.
      bs_out = bs_ones ? 1'b1 : 1'($urandom);
      if (exp_cfg) begin
        b = q.pop_front();
        check("bs_in", 32'(bs_in), 32'(b));
        shifted++;
        m_crc = crc_next(m_crc, bs_out);
      end

      ab_now = (phase == 0) && (abort_at >= 0) && (sh0 == abort_at) && !ab_fired;
      if (ab_now) ab_fired = 1'b1;
      abort = ab_now || (phase == 2 && abort_in_done);
      start = (phase <= 2) && ($urandom_range(0, 15) == 0);

      if (bi < int'(NBYTES)) begin
        if (wait_c > 0) begin
          bus.in_valid = 1'b0;
          wait_c--;
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = byt[bi];
        end
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
      end

      if (bus.in_valid && bus.in_ready && bi < int'(NBYTES) && phase == 0 && !ab_now) begin
        n = (int'(CHAIN_LEN) - req >= 8) ? 8 : int'(CHAIN_LEN) - req;
        for (int j = 0; j < n; j++) q.push_back(byt[bi][j]);
        req += n;
        bi++;
        if (bi < int'(NBYTES)) wait_c = gap[bi];
      end

      case (phase)
        0: begin
          if (ab_now) begin
            phase = 4;
            m_aborted = 1'b1;
          end else if (shifted == int'(CHAIN_LEN)) begin
            phase = 1;
            nnc = 0;
          end
        end
        1: begin
          nnc++;
          if (nnc == int'(NN_PULSE)) phase = 2;
        end
        2: phase = 3;
        default: phase = 5;
      endcase
    end
    if (phase != 5) check("timeout", 32'd1, 32'd0);
    bus.in_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Quiet idle cycles: nothing moves, CRC and flags hold.
  task automatic idle_check(input int ncyc, input logic [CNT_W-1:0] exp_cnt);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      bs_out = 1'($urandom);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_cfg", 32'(config_en), 32'd0);
      check("idle_ready", 32'(bus.in_ready), 32'd0);
      check("idle_aborted", 32'(aborted), 32'(m_aborted));
      check("idle_bitcnt", 32'(bit_count), 32'(exp_cnt));
      check_crc("idle_crc");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bs_out = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_cfg", 32'(config_en), 32'd0);
    check("rst_bs_in", 32'(bs_in), 32'd0);
    check("rst_reset_nn", 32'(reset_nn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_bitcnt", 32'(bit_count), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check_crc("rst_crc");
    rst_n = 1'b1;
    idle_check(2, '0);

    // Gap-free stream, first byte 0xA5, bs_out held at 1.
    run_load(0, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_check(4, CNT_W'(CHAIN_LEN));

    // Ten-cycle valid drop after byte 3, last byte 0xFF, abort during DONE.
    run_load(2, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_check(3, CNT_W'(CHAIN_LEN));

    // Random gaps, abort at bit_count 100.
    run_load(1, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_check(3, CNT_W'(101));

    // Abort while idle leaves the sticky flag and state alone.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    idle_check(2, CNT_W'(101));

    // Start together with abort while idle: start wins and clears aborted.
    run_load(1, -1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_check(2, CNT_W'(CHAIN_LEN));

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    repeat (20) @(negedge clk);
    check("midload_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_cfg", 32'(config_en), 32'd0);
    check("arst_bitcnt", 32'(bit_count), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_crc = 8'h00;
    m_aborted = 1'b0;
    idle_check(2, '0);

    // Recovery load with random gaps.
    run_load(1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_check(2, CNT_W'(CHAIN_LEN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
